// File: rtl/dct_pkg.sv
// Shared types for the DCT front end: fetch tag, fetch FSM states and image geometry.
package dct_pkg;

    localparam int PIX_W        = 8;
    localparam int PIX_PER_WORD = 8;
    localparam int IMG_WORDS    = 32768;
    localparam int BLK_W        = 12;
    localparam int ROW_W        = 3;
    localparam int TAG_W        = ROW_W + BLK_W;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [BLK_W-1:0] blk;
    } fetch_tag_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/dct_fetch_fifo.sv
// Small synchronous skid FIFO holding returned SRAM words with their block/row tag.
module dct_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 79
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Head is forced to zero when empty so the tag outputs read 0 out of reset.
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dct_block_fetcher.sv
// Reads the raster-ordered input image from SRAM and streams it to the DCT core in 8x8-block order,
// one block row per beat, with credit-based issue so the skid FIFO can absorb core backpressure.
module dct_block_fetcher
    import dct_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int WPR_LOG2   = 6,
    parameter int DATA_W     = 64,
    parameter int READ_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_row,
    output logic              out_last,
    output logic [11:0]       out_blk
);

    localparam int BR_W   = ADDR_W - WPR_LOG2 - ROW_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_W = DATA_W + TAG_W;

    fetch_state_t            state_q, state_d;
    logic [ROW_W-1:0]        r_q, r_d;
    logic [WPR_LOG2-1:0]     bc_q, bc_d;
    logic [BR_W-1:0]         br_q, br_d;
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic                    done_q, done_d;
    logic [READ_LAT-1:0]     vld_pipe_q, vld_pipe_d;
    fetch_tag_t [READ_LAT-1:0] tag_pipe_q, tag_pipe_d;

    logic                    issue, last_addr, ret, pop, final_pop;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty, fifo_full;
    logic [FIFO_W-1:0]       fifo_rdata;
    fetch_tag_t              head_tag;

    // Credit counts every word already owned by the fetcher (queued or still in the SRAM pipe).
    assign issue     = (state_q == ISSUE) &&
                       (({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH));
    assign last_addr = &{br_q, r_q, bc_q};
    assign ret       = vld_pipe_q[READ_LAT-1];
    assign pop       = out_valid & out_ready;
    assign head_tag  = fifo_rdata[TAG_W-1:0];
    assign final_pop = pop && (&head_tag.row) && (&head_tag.blk);

    assign mem_rd_en = issue;
    assign mem_addr  = {br_q, r_q, bc_q};
    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_rdata[FIFO_W-1 -: DATA_W];
    assign out_row   = head_tag.row;
    assign out_blk   = head_tag.blk;
    assign out_last  = &head_tag.row;
    // busy covers the done cycle so a start coincident with done is dropped.
    assign busy      = (state_q != IDLE) | done_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        bc_d    = bc_q;
        br_d    = br_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                r_d  = '0;
                bc_d = '0;
                br_d = '0;
                if (start && !done_q) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    if (last_addr) begin
                        state_d = DRAIN;
                    end else begin
                        // r fastest, then block column, then block row.
                        {br_d, bc_d, r_d} = {br_q, bc_q, r_q} + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (final_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, ret})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        vld_pipe_d        = vld_pipe_q;
        tag_pipe_d        = tag_pipe_q;
        vld_pipe_d[0]     = issue;
        tag_pipe_d[0].row = r_q;
        tag_pipe_d[0].blk = BLK_W'({br_q, bc_q});
        for (int i = 1; i < READ_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            r_q        <= '0;
            bc_q       <= '0;
            br_q       <= '0;
            inflight_q <= '0;
            done_q     <= 1'b0;
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            bc_q       <= bc_d;
            br_q       <= br_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            vld_pipe_q <= vld_pipe_d;
            tag_pipe_q <= tag_pipe_d;
        end
    end

    dct_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ret),
        .wdata ({mem_rdata, tag_pipe_q[READ_LAT-1]}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule
